// File: rtl/irq_sequencer_pkg.sv
// Shared constants and state encoding for the interrupt sequencer.
package irq_sequencer_pkg;

    localparam int unsigned SREG_I = 7;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    // Existing timer-0 vector table entries used to choose VEC_BASE/VEC_STRIDE.
    localparam int unsigned TIM0_COMPA_ISR = 1;
    localparam int unsigned TIM0_COMPB_ISR = 2;
    localparam int unsigned TIM0_OVF_ISR   = 3;
    localparam int unsigned TIM0_ISR_STRIDE = TIM0_COMPB_ISR - TIM0_COMPA_ISR;

endpackage

// File: rtl/irq_sequencer_prio_encoder.sv
// Combinational priority encoder: reports the index of the lowest set bit.
module prio_encoder #(
    parameter int unsigned WIDTH = 3,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Vectored interrupt sequencer: fixed-priority arbitration, irq/ack handshake,
// flag-clear pulse on ack, and request blocking until RETI (no nesting).
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned I_ADDR_WIDTH = 10,
    parameter int unsigned NUM_SRC      = 3,
    parameter int unsigned VEC_BASE     = TIM0_COMPA_ISR,
    parameter int unsigned VEC_STRIDE   = TIM0_ISR_STRIDE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   mem_tifr,
    input  logic [DATA_WIDTH-1:0]   mem_timsk,
    input  logic [DATA_WIDTH-1:0]   mem_sreg,
    input  logic                    cpu_ack,
    input  logic                    cpu_reti,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    output logic [DATA_WIDTH-1:0]   flag_clr,
    output logic                    in_service
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    irq_state_e              state_q, state_d;
    logic                    irq_q, irq_d;
    logic [I_ADDR_WIDTH-1:0] vector_q, vector_d;
    logic [DATA_WIDTH-1:0]   flag_clr_q, flag_clr_d;
    logic                    in_service_q, in_service_d;
    logic [IDX_W-1:0]        sel_idx_q, sel_idx_d;

    logic [NUM_SRC-1:0]      req_vec;
    logic [NUM_SRC-1:0]      sel_hot;
    logic                    win_valid;
    logic [IDX_W-1:0]        win_idx;
    logic                    gie;
    logic                    unused_bits;

    assign req_vec     = mem_tifr[NUM_SRC-1:0] & mem_timsk[NUM_SRC-1:0];
    assign gie         = mem_sreg[SREG_I];
    assign sel_hot     = NUM_SRC'(1) << sel_idx_q;
    assign unused_bits = ^{mem_tifr, mem_timsk, mem_sreg};

    prio_encoder #(
        .WIDTH (NUM_SRC)
    ) u_prio (
        .req   (req_vec),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Next-state and output logic; flag_clr defaults to zero so it only pulses.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        vector_d     = vector_q;
        flag_clr_d   = '0;
        in_service_d = in_service_q;
        sel_idx_d    = sel_idx_q;

        case (state_q)
            IRQ_IDLE: begin
                if (gie && win_valid) begin
                    sel_idx_d = win_idx;
                    vector_d  = I_ADDR_WIDTH'(VEC_BASE)
                              + I_ADDR_WIDTH'(win_idx) * I_ADDR_WIDTH'(VEC_STRIDE);
                    irq_d     = 1'b1;
                    state_d   = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                // Ack wins over a simultaneous withdrawal.
                if (cpu_ack) begin
                    irq_d        = 1'b0;
                    flag_clr_d   = DATA_WIDTH'(sel_hot);
                    in_service_d = 1'b1;
                    state_d      = IRQ_SERVICE;
                end else if (!gie || ((req_vec & sel_hot) == '0)) begin
                    irq_d   = 1'b0;
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (cpu_reti) begin
                    in_service_d = 1'b0;
                    state_d      = IRQ_IDLE;
                end
            end
            default: begin
                irq_d        = 1'b0;
                in_service_d = 1'b0;
                state_d      = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IRQ_IDLE;
            irq_q        <= 1'b0;
            vector_q     <= '0;
            flag_clr_q   <= '0;
            in_service_q <= 1'b0;
            sel_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            vector_q     <= vector_d;
            flag_clr_q   <= flag_clr_d;
            in_service_q <= in_service_d;
            sel_idx_q    <= sel_idx_d;
        end
    end

    assign irq        = irq_q;
    assign vector     = vector_q;
    assign flag_clr   = flag_clr_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Randomized plus directed bench for irq_sequencer against a behavioural model.
module tb_irq_sequencer;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 10;
    localparam int unsigned NSRC = 3;
    localparam int unsigned VB   = 1;
    localparam int unsigned VS   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] mem_tifr = '0, mem_timsk = '0, mem_sreg = '0;
    logic          cpu_ack = 1'b0, cpu_reti = 1'b0;
    logic          irq;
    logic [AW-1:0] vector;
    logic [DW-1:0] flag_clr;
    logic          in_service;

    int n_checks = 0;
    int n_errors = 0;

    // Model: whether a request is outstanding, whether an ISR is running,
    // which source was chosen, and the last presented vector.
    bit            m_pending, m_busy;
    int            m_src;
    logic [AW-1:0] m_vec;
    logic [DW-1:0] m_clr;

    irq_sequencer #(
        .DATA_WIDTH   (DW),
        .I_ADDR_WIDTH (AW),
        .NUM_SRC      (NSRC),
        .VEC_BASE     (VB),
        .VEC_STRIDE   (VS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_tifr   (mem_tifr),
        .mem_timsk  (mem_timsk),
        .mem_sreg   (mem_sreg),
        .cpu_ack    (cpu_ack),
        .cpu_reti   (cpu_reti),
        .irq        (irq),
        .vector     (vector),
        .flag_clr   (flag_clr),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour, evaluated once per rising edge on the sampled inputs.
    task automatic model_step();
        int win;
        m_clr = '0;
        if (reset) begin
            m_pending = 0; m_busy = 0; m_src = 0; m_vec = '0;
        end else if (m_busy) begin
            if (cpu_reti) m_busy = 0;
        end else if (m_pending) begin
            if (cpu_ack) begin
                m_pending = 0; m_busy = 1;
                m_clr = DW'(1 << m_src);
            end else if (!mem_sreg[7] || !mem_tifr[m_src] || !mem_timsk[m_src]) begin
                m_pending = 0;
            end
        end else begin
            win = -1;
            for (int i = NSRC - 1; i >= 0; i--)
                if (mem_tifr[i] && mem_timsk[i]) win = i;
            if (mem_sreg[7] && win >= 0) begin
                m_pending = 1;
                m_src = win;
                m_vec = AW'((VB + win * VS) % (1 << AW));
            end
        end
    endtask

    task automatic cyc(input logic [7:0] f, input logic [7:0] m, input logic [7:0] s,
                       input logic a, input logic r, input logic rs);
        mem_tifr = f; mem_timsk = m; mem_sreg = s;
        cpu_ack = a; cpu_reti = r; reset = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("irq", 32'(irq), 32'(m_pending));
        check("vector", 32'(vector), 32'(m_vec));
        check("flag_clr", 32'(flag_clr), 32'(m_clr));
        check("in_service", 32'(in_service), 32'(m_busy));
    endtask

    initial begin
        logic [7:0] f, m, s;

        // Reset
        cyc(8'h00, 8'h00, 8'h00, 0, 0, 1);
        check("rst_irq", 32'(irq), 0);
        check("rst_vec", 32'(vector), 0);

        // Basic flow
        cyc(8'h01, 8'h01, 8'h80, 0, 0, 0);
        check("basic_irq", 32'(irq), 1);
        check("basic_vec", 32'(vector), 1);
        cyc(8'h01, 8'h01, 8'h80, 1, 0, 0);
        check("basic_clr", 32'(flag_clr), 32'h01);
        check("basic_svc", 32'(in_service), 1);
        cyc(8'h00, 8'h01, 8'h80, 0, 0, 0);
        check("basic_clr_once", 32'(flag_clr), 0);
        cyc(8'h00, 8'h01, 8'h80, 0, 1, 0);
        check("basic_reti", 32'(in_service), 0);

        // Priority and freeze
        cyc(8'h06, 8'h07, 8'h80, 0, 0, 0);
        check("prio_vec", 32'(vector), 2);
        cyc(8'h07, 8'h07, 8'h80, 0, 0, 0);
        check("freeze_vec", 32'(vector), 2);
        cyc(8'h07, 8'h07, 8'h80, 0, 1, 0);
        check("reti_in_req", 32'(irq), 1);
        cyc(8'h07, 8'h07, 8'h80, 1, 0, 0);
        check("freeze_clr", 32'(flag_clr), 32'h02);
        cyc(8'h05, 8'h07, 8'h80, 1, 0, 0);
        check("nest_irq", 32'(irq), 0);
        cyc(8'h05, 8'h07, 8'h80, 1, 1, 0);
        check("ack_reti_svc", 32'(in_service), 0);
        check("reti_irq0", 32'(irq), 0);
        cyc(8'h05, 8'h07, 8'h80, 0, 0, 0);
        check("rereq_irq", 32'(irq), 1);
        check("rereq_vec", 32'(vector), 1);

        // Withdrawal, then withdraw+ack
        cyc(8'h05, 8'h07, 8'h00, 0, 0, 0);
        check("wd_irq", 32'(irq), 0);
        check("wd_vec", 32'(vector), 1);
        check("wd_clr", 32'(flag_clr), 0);
        cyc(8'h01, 8'h01, 8'h80, 0, 0, 0);
        cyc(8'h01, 8'h01, 8'h00, 1, 0, 0);
        check("wdack_clr", 32'(flag_clr), 32'h01);

        // Reset in SERVICE, then in REQ
        cyc(8'h00, 8'h00, 8'h80, 0, 0, 1);
        check("rst_svc", 32'(in_service), 0);
        check("rst_svc_vec", 32'(vector), 0);
        cyc(8'h04, 8'h04, 8'h80, 0, 0, 0);
        check("post_rst_vec", 32'(vector), 3);
        cyc(8'h04, 8'h04, 8'h80, 0, 0, 1);
        check("rst_req_irq", 32'(irq), 0);

        // Gating
        for (int i = 0; i < 20; i++) cyc(8'h07, 8'h07, 8'h00, 0, 0, 0);
        check("gie_gate", 32'(irq), 0);
        for (int i = 0; i < 4; i++) cyc(8'h07, 8'h00, 8'h80, 0, 0, 0);
        check("mask_gate", 32'(irq), 0);
        for (int i = 0; i < 4; i++) cyc(8'h08, 8'hFF, 8'h80, 1, 1, 0);
        check("oor_gate", 32'(irq), 0);

        // Randomized traffic
        f = '0; m = 8'h07; s = 8'h80;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) f = 8'($urandom);
            if ($urandom_range(0, 15) == 0) m = 8'($urandom);
            if ($urandom_range(0, 15) == 0) s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h80;
            cyc(f, m, s, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Vectored interrupt sequencer for the CPU core, sitting between peripheral flag/mask registers (TIFR/TIMSK-style) plus SREG and the control unit's interrupt entry/exit logic.
- Arbitrates pending sources by fixed priority and presents one request with a stable vector.
- Performs an irq/ack handshake with the CPU, pulses a flag-clear back to the peripheral on ack, and blocks further requests until the ISR returns (no nesting).

Parameters:
- DATA_WIDTH, 8, width of flag, mask and status register inputs
- I_ADDR_WIDTH, 10, width of the instruction-address vector output
- NUM_SRC, 3, number of interrupt sources; uses bits [NUM_SRC-1:0] of flag/mask; 1..DATA_WIDTH
- VEC_BASE, 1, vector address of source 0
- VEC_STRIDE, 1, vector address increment per source index

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_tifr  in  DATA_WIDTH  peripheral interrupt flags; bit i = source i pending
- mem_timsk  in  DATA_WIDTH  interrupt masks; bit i = source i enabled
- mem_sreg  in  DATA_WIDTH  status register; bit 7 (I) = global interrupt enable
- cpu_ack  in  1  one-cycle pulse: CPU has taken the vector and is entering the ISR
- cpu_reti  in  1  one-cycle pulse: CPU executed RETI
- irq  out  1  interrupt request to CPU
- vector  out  I_ADDR_WIDTH  ISR address for the current/last request
- flag_clr  out  DATA_WIDTH  one-hot, one-cycle pulse clearing the serviced flag bit
- in_service  out  1  high while an ISR is active

Behaviour:
- Reset: irq=0, vector=0, flag_clr=0, in_service=0, state=IDLE. Reset in any state aborts the request or service silently; no flag_clr is emitted.
- Candidate set: req_vec = mem_tifr[NUM_SRC-1:0] & mem_timsk[NUM_SRC-1:0]. Request is qualified when mem_sreg[7]=1 and req_vec!=0.
- Priority: lowest set index wins (0 = highest priority).
- Vector arithmetic: vector = VEC_BASE + idx*VEC_STRIDE, computed in I_ADDR_WIDTH bits; overflow wraps modulo 2^I_ADDR_WIDTH.
- All outputs are registered.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If qualified: sel_idx <= winner, vector <= computed address, irq <= 1, go to REQ. Latency is 1 cycle from qualifying inputs to irq=1.
  - Otherwise stay. vector holds its previous value and is never cleared except by reset.
  - cpu_ack and cpu_reti are ignored.
- REQ:
  - irq stays 1. vector and sel_idx are frozen; a higher-priority source appearing here does not re-arbitrate.
  - On cpu_ack=1: irq <= 0, flag_clr <= (1 << sel_idx) for exactly one cycle, in_service <= 1, go to SERVICE.
  - Else, if mem_sreg[7]=0, or the selected bit of mem_tifr or mem_timsk is 0: withdraw, irq <= 0, go to IDLE, no flag_clr, vector retained.
  - ack beats withdrawal in the same cycle.
  - cpu_reti is ignored.
- SERVICE:
  - irq stays 0 regardless of pending sources (no nesting).
  - On cpu_reti: in_service <= 0, go to IDLE. The earliest re-request is irq=1 two cycles after the reti cycle.
  - cpu_ack is ignored.
- flag_clr is 0 in every cycle except the one after an accepted ack.
- Bits of flag/mask at index >= NUM_SRC are ignored, and flag_clr drives them to 0.
- cpu_ack and cpu_reti asserted together:
  - In REQ: the ack is honoured.
  - In SERVICE: the reti is honoured.

Decomposition:
- defines.vh:
  - SREG_I bit index (7)
  - FSM state encodings (IRQ_IDLE, IRQ_REQ, IRQ_SERVICE)
  - Existing TIM0_*_ISR vector constants, used to pick VEC_BASE/VEC_STRIDE at instantiation.
- Sub-module prio_encoder (parameter WIDTH): input bit vector; outputs valid plus the binary index of the lowest set bit. Purely combinational.
- irq_sequencer instantiates one prio_encoder and holds the FSM and output registers.

Test Plan:
- Basic flow:
  - Stimulus: sreg=0x80, timsk=0x01, tifr=0x01.
  - Response: irq=1 and vector=1 the next cycle.
  - Then cpu_ack pulse → irq=0, flag_clr=0x01 for exactly one cycle, in_service=1.
  - Then cpu_reti → in_service=0.
- Priority and freeze:
  - Stimulus: tifr=0x06, timsk=0x07, sreg=0x80.
  - Response: vector=2 (idx 1).
  - Then set tifr bit0 while in REQ → vector stays 2 until ack, flag_clr=0x02.
  - After reti, irq=1 with vector=1 two cycles later.
- Global/mask gating:
  - sreg=0x00 with tifr=timsk=0x07 → irq stays 0 for 20 cycles.
  - timsk=0x00, sreg=0x80 → irq stays 0.
  - tifr=0x08 (out of range) → irq stays 0.
- Withdrawal:
  - Stimulus: in REQ, clear sreg bit 7 with no ack.
  - Response: irq=0 the next cycle, no flag_clr, vector unchanged.
  - Same cycle withdraw+ack → ack honoured, flag_clr pulses.
- No nesting and ignored handshakes:
  - In SERVICE, tifr=0x07 → irq=0 until reti.
  - cpu_ack in IDLE/SERVICE and cpu_reti in IDLE/REQ → no state or output change.
- Reset mid-operation:
  - Reset asserted in REQ and in SERVICE → irq=0, vector=0, flag_clr=0, in_service=0 the next cycle.
  - Re-request follows normally after reset deasserts.
